// File: rtl/draw_rect_pkg.sv
// Shared screen geometry, counter widths and colour constants for the draw_rect pipeline.
package draw_rect_pkg;

  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;
  localparam int HC_W     = 11;
  localparam int VC_W     = 10;
  localparam int RGB_W    = 12;

  localparam logic [RGB_W-1:0] BLACK = 12'h000;
  localparam logic [RGB_W-1:0] WHITE = 12'hFFF;

  typedef struct packed {
    logic [HC_W-1:0] hcount;
    logic [VC_W-1:0] vcount;
    logic            hsync;
    logic            vsync;
    logic            hblnk;
    logic            vblnk;
  } timing_t;

  localparam int TIMING_W = $bits(timing_t);

endpackage

// File: rtl/draw_rect_signal_delay.sv
// Generic CLK_DEL-deep register delay line with synchronous active-high clear.
module signal_delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [CLK_DEL];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CLK_DEL; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout = pipe_q[CLK_DEL-1];

endmodule

// File: rtl/draw_rect.sv
// Overlays a filled rectangle on the pixel stream with a 2-cycle latency; position is
// double-buffered and swapped at frame start. DRAW_RECT_BORDER_EN adds a white 1-pixel outline.
module draw_rect
  import draw_rect_pkg::*;
#(
  parameter int          RECT_W     = 64,
  parameter int          RECT_H     = 48,
  parameter logic [11:0] RECT_COLOR = 12'hF00
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [HC_W-1:0] hcount_in,
  input  logic [VC_W-1:0] vcount_in,
  input  logic            hsync_in,
  input  logic            vsync_in,
  input  logic            hblnk_in,
  input  logic            vblnk_in,
  input  logic [11:0]     rgb_in,
  input  logic [HC_W-1:0] xpos,
  input  logic [VC_W-1:0] ypos,
  input  logic            pos_valid,
  output logic [HC_W-1:0] hcount_out,
  output logic [VC_W-1:0] vcount_out,
  output logic            hsync_out,
  output logic            vsync_out,
  output logic            hblnk_out,
  output logic            vblnk_out,
  output logic [11:0]     rgb_out
);

  localparam logic [HC_W:0] RECT_W_X = (HC_W+1)'(RECT_W);
  localparam logic [VC_W:0] RECT_H_X = (VC_W+1)'(RECT_H);

  logic [HC_W-1:0] act_x_q, act_x_d, pend_x_q, pend_x_d;
  logic [VC_W-1:0] act_y_q, act_y_d, pend_y_q, pend_y_d;
  logic            pend_flag_q, pend_flag_d;
  logic            vblnk_prev_q;
  logic            frame_start;

  always_comb begin
    frame_start = vblnk_in & ~vblnk_prev_q;
    act_x_d     = act_x_q;
    act_y_d     = act_y_q;
    pend_x_d    = pend_x_q;
    pend_y_d    = pend_y_q;
    pend_flag_d = pend_flag_q;
    if (pos_valid) begin
      pend_x_d    = xpos;
      pend_y_d    = ypos;
      pend_flag_d = 1'b1;
    end
    // A strobe coinciding with frame start bypasses the pending buffer.
    if (frame_start) begin
      if (pos_valid) begin
        act_x_d     = xpos;
        act_y_d     = ypos;
        pend_flag_d = 1'b0;
      end else if (pend_flag_q) begin
        act_x_d     = pend_x_q;
        act_y_d     = pend_y_q;
        pend_flag_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_x_q      <= '0;
      act_y_q      <= '0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      pend_flag_q  <= 1'b0;
      vblnk_prev_q <= 1'b0;
    end else begin
      act_x_q      <= act_x_d;
      act_y_q      <= act_y_d;
      pend_x_q     <= pend_x_d;
      pend_y_q     <= pend_y_d;
      pend_flag_q  <= pend_flag_d;
      vblnk_prev_q <= vblnk_in;
    end
  end

  // One extra bit on the end coordinates so an edge-hugging rectangle clips instead of wrapping.
  logic [HC_W:0] x_end;
  logic [VC_W:0] y_end;
  logic          inside_d;

  assign x_end    = {1'b0, act_x_q} + RECT_W_X;
  assign y_end    = {1'b0, act_y_q} + RECT_H_X;
  assign inside_d = (hcount_in >= act_x_q) && ({1'b0, hcount_in} < x_end) &&
                    (vcount_in >= act_y_q) && ({1'b0, vcount_in} < y_end);

`ifdef DRAW_RECT_BORDER_EN
  logic border_d, border_p1_q;
  assign border_d = (hcount_in == act_x_q) || ({1'b0, hcount_in} == x_end - 1'b1) ||
                    (vcount_in == act_y_q) || ({1'b0, vcount_in} == y_end - 1'b1);
`endif

  // Stage 1: timing bundle, background colour and inside flag
  timing_t    tim_in, tim_p1, tim_p2;
  logic [11:0] rgb_p1_q;
  logic        inside_p1_q;

  assign tim_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                    vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

  signal_delay #(.WIDTH(TIMING_W), .CLK_DEL(1)) u_delay_p1 (
    .clk  (clk),
    .rst  (rst),
    .din  (tim_in),
    .dout (tim_p1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_p1_q    <= '0;
      inside_p1_q <= 1'b0;
`ifdef DRAW_RECT_BORDER_EN
      border_p1_q <= 1'b0;
`endif
    end else begin
      rgb_p1_q    <= rgb_in;
      inside_p1_q <= inside_d;
`ifdef DRAW_RECT_BORDER_EN
      border_p1_q <= border_d;
`endif
    end
  end

  // Stage 2: colour selection registered alongside the delayed timing bundle
  logic [11:0] rgb_d, rgb_q;

  always_comb begin
    rgb_d = rgb_p1_q;
    if (inside_p1_q) begin
`ifdef DRAW_RECT_BORDER_EN
      rgb_d = border_p1_q ? WHITE : RECT_COLOR;
`else
      rgb_d = RECT_COLOR;
`endif
    end
    if (tim_p1.hblnk || tim_p1.vblnk) rgb_d = BLACK;
  end

  signal_delay #(.WIDTH(TIMING_W), .CLK_DEL(1)) u_delay_p2 (
    .clk  (clk),
    .rst  (rst),
    .din  (tim_p1),
    .dout (tim_p2)
  );

  always_ff @(posedge clk) begin
    if (rst) rgb_q <= '0;
    else     rgb_q <= rgb_d;
  end

  assign hcount_out = tim_p2.hcount;
  assign vcount_out = tim_p2.vcount;
  assign hsync_out  = tim_p2.hsync;
  assign vsync_out  = tim_p2.vsync;
  assign hblnk_out  = tim_p2.hblnk;
  assign vblnk_out  = tim_p2.vblnk;
  assign rgb_out    = rgb_q;

endmodule

// File: tb/tb_draw_rect.sv
// Directed table-driven bench for draw_rect (default 64x48, colour F00).
module tb_draw_rect;

  localparam logic [11:0] BG  = 12'h0A5;
  localparam logic [11:0] RC  = 12'hF00;
`ifdef DRAW_RECT_BORDER_EN
  localparam logic [11:0] EDG = 12'hFFF;
`else
  localparam logic [11:0] EDG = 12'hF00;
`endif
  localparam logic [11:0] BLK = 12'h000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount_in = '0, xpos = '0;
  logic [9:0]  vcount_in = '0, ypos = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic        pos_valid = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  always #5 clk = ~clk;

  draw_rect dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .pos_valid(pos_valid),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  typedef struct {
    logic        pv;
    logic [10:0] x;
    logic [9:0]  y;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec_no = 0;

  function automatic vec_t mk(input logic pv, input logic [10:0] x, input logic [9:0] y,
                              input logic [10:0] hc, input logic [9:0] vc,
                              input logic hb, input logic vb, input logic [11:0] exp);
    vec_t v;
    v.pv = pv; v.x = x; v.y = y; v.hc = hc; v.vc = vc;
    v.hs = hc[0] ^ vc[1]; v.vs = vc[0]; v.hb = hb; v.vb = vb;
    v.rgb = BG; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    pos_valid = v.pv; xpos = v.x; ypos = v.y;
    hcount_in = v.hc; vcount_in = v.vc;
    hsync_in = v.hs; vsync_in = v.vs; hblnk_in = v.hb; vblnk_in = v.vb;
    rgb_in = v.rgb;
  endtask

  // Streams the table; outputs seen after edge i belong to the vector driven before edge i-1.
  task automatic run_table();
    vec_t v;
    for (int i = 0; i <= tbl.size(); i++) begin
      if (i < tbl.size()) drive(tbl[i]);
      else pos_valid = 1'b0;
      @(posedge clk); #1;
      if (i >= 1) begin
        v = tbl[i-1];
        check($sformatf("vec%0d rgb (%0d,%0d)", vec_no, v.hc, v.vc), 32'(rgb_out), 32'(v.exp));
        check($sformatf("vec%0d timing", vec_no),
              32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
              32'({v.hc, v.vc, v.hs, v.vs, v.hb, v.vb}));
        vec_no++;
      end
    end
    tbl.delete();
  endtask

  initial begin
    // Reset with busy inputs: every output and the active position must read zero.
    rst = 1'b1;
    drive(mk(1'b1, 11'd5, 10'd5, 11'd120, 10'd60, 1'b0, 1'b0, BLK));
    hsync_in = 1'b1; vsync_in = 1'b1; rgb_in = 12'hABC;
    for (int c = 0; c < 3; c++) begin
      vblnk_in = c[0];
      @(posedge clk); #1;
      check($sformatf("reset outputs c%0d", c),
            32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'd0);
      check($sformatf("reset rgb c%0d", c), 32'(rgb_out), 32'd0);
    end
    check("reset act_x", 32'(dut.act_x_q), 32'd0);
    check("reset act_y", 32'(dut.act_y_q), 32'd0);
    check("reset pend_flag", 32'(dut.pend_flag_q), 32'd0);
    rst = 1'b0;

    // Default position (0,0), strobe (100,50), blanking latency, then frame start.
    tbl.push_back(mk(0, 0, 0,   10,  10, 0, 0, RC));
    tbl.push_back(mk(0, 0, 0,    0,   0, 0, 0, EDG));
    tbl.push_back(mk(1, 100, 50, 200, 200, 0, 0, BG));
    tbl.push_back(mk(0, 0, 0,   20,  20, 0, 0, RC));
    tbl.push_back(mk(0, 0, 0, 1022, 767, 0, 0, BG));
    tbl.push_back(mk(0, 0, 0, 1023, 767, 0, 0, BG));
    tbl.push_back(mk(0, 0, 0, 1024, 767, 1, 0, BLK));
    tbl.push_back(mk(0, 0, 0, 1025, 767, 1, 0, BLK));
    tbl.push_back(mk(0, 0, 0,    0, 768, 0, 1, BLK));
    tbl.push_back(mk(0, 0, 0,    5, 768, 1, 1, BLK));
    // Static rectangle at (100,50): columns 100..163, lines 50..97.
    tbl.push_back(mk(0, 0, 0,   99,  50, 0, 0, BG));
    tbl.push_back(mk(0, 0, 0,  100,  50, 0, 0, EDG));
    tbl.push_back(mk(0, 0, 0,  163,  50, 0, 0, EDG));
    tbl.push_back(mk(0, 0, 0,  164,  50, 0, 0, BG));
    tbl.push_back(mk(0, 0, 0,  130,  49, 0, 0, BG));
    tbl.push_back(mk(0, 0, 0,  130,  70, 0, 0, RC));
    tbl.push_back(mk(0, 0, 0,  130,  97, 0, 0, EDG));
    tbl.push_back(mk(0, 0, 0,  130,  98, 0, 0, BG));
    tbl.push_back(mk(0, 0, 0,  100,  97, 0, 0, EDG));
    tbl.push_back(mk(0, 0, 0, 1023, 500, 0, 0, BG));
    tbl.push_back(mk(0, 0, 0,   10,  10, 0, 0, BG));
    tbl.push_back(mk(0, 0, 0,  130,  70, 1, 0, BLK));
    // Mid-frame update at line 300: old position holds until the next frame.
    tbl.push_back(mk(1, 400, 300, 10, 300, 0, 0, BG));
    tbl.push_back(mk(0, 0, 0,  130,  60, 0, 0, RC));
    tbl.push_back(mk(0, 0, 0,  420, 310, 0, 0, BG));
    tbl.push_back(mk(0, 0, 0,    0, 768, 0, 1, BLK));
    tbl.push_back(mk(0, 0, 0,  420, 310, 0, 0, RC));
    tbl.push_back(mk(0, 0, 0,  130,  60, 0, 0, BG));
    tbl.push_back(mk(0, 0, 0,  400, 300, 0, 0, EDG));
    tbl.push_back(mk(0, 0, 0,  463, 347, 0, 0, EDG));
    tbl.push_back(mk(0, 0, 0,  464, 347, 0, 0, BG));
    // Clipping at (1000,740).
    tbl.push_back(mk(1, 1000, 740, 5, 5, 0, 0, BG));
    tbl.push_back(mk(0, 0, 0,    0, 768, 0, 1, BLK));
    tbl.push_back(mk(0, 0, 0, 1000, 740, 0, 0, EDG));
    tbl.push_back(mk(0, 0, 0, 1023, 767, 0, 0, RC));
    tbl.push_back(mk(0, 0, 0, 1023, 740, 0, 0, EDG));
    tbl.push_back(mk(0, 0, 0,  999, 767, 0, 0, BG));
    tbl.push_back(mk(0, 0, 0, 1010, 739, 0, 0, BG));
    tbl.push_back(mk(0, 0, 0,    0, 740, 0, 0, BG));
    tbl.push_back(mk(0, 0, 0, 1010,   0, 0, 0, BG));
    tbl.push_back(mk(0, 0, 0,    0,   0, 0, 0, BG));
    // Strobe on the vblnk rising edge itself.
    tbl.push_back(mk(1, 200, 100, 0, 768, 0, 1, BLK));
    tbl.push_back(mk(0, 0, 0,  200, 100, 0, 0, EDG));
    tbl.push_back(mk(0, 0, 0,  230, 120, 0, 0, RC));
    tbl.push_back(mk(0, 0, 0, 1000, 740, 0, 0, BG));
    run_table();
    check("simul pend_flag", 32'(dut.pend_flag_q), 32'd0);
    check("simul act_x", 32'(dut.act_x_q), 32'd200);

    // Mid-frame reset must discard a pending position.
    tbl.push_back(mk(1, 500, 500, 10, 10, 0, 0, BG));
    run_table();
    rst = 1'b1;
    drive(mk(0, 0, 0, 300, 300, 0, 0, BLK));
    @(posedge clk); #1;
    check("midreset rgb", 32'(rgb_out), 32'd0);
    check("midreset pend_flag", 32'(dut.pend_flag_q), 32'd0);
    rst = 1'b0;
    tbl.push_back(mk(0, 0, 0,    0,   0, 0, 0, EDG));
    tbl.push_back(mk(0, 0, 0,    0, 768, 0, 1, BLK));
    tbl.push_back(mk(0, 0, 0,   10,  10, 0, 0, RC));
    tbl.push_back(mk(0, 0, 0,  500, 500, 0, 0, BG));
    run_table();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
